sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have these ports:
- clk50  in  1  sole clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- if_req_i  in  1  instruction-fetch read request, held until ack
- if_addr_i  in  20  IF word address
- if_rdata_o  out  32  IF read data
- if_ack_o  out  1  IF completion pulse
- mem_req_i  in  1  data-port request, held until ack
- mem_we_i  in  1  1=write, 0=read
- mem_addr_i  in  20  data word address
- mem_wdata_i  in  32  store data
- mem_be_i  in  4  store byte enables, active-high, bit n = byte n
- mem_rdata_o  out  32  data-port read data
- mem_ack_o  out  1  data-port completion pulse
- stall_o  out  1  pipeline stall
- sram_addr_o  out  20  SRAM address
- sram_wdata_o  out  32  SRAM write data
- sram_rdata_i  in  32  SRAM read data
- sram_drive_o  out  1  1 = block drives SRAM data bus
- sram_ce_n_o, sram_oe_n_o, sram_we_n_o  out  1 each  active-low chip/output/write enables
- sram_be_n_o  out  4  active-low byte enables

Function
REQ-002 FSM states SHALL be IDLE, RD1, RD2, WR1, WR2, WR3, DONE; all SRAM outputs registered.
REQ-003 In IDLE, a port with req high SHALL be granted; neither high -> stay IDLE.
REQ-004 Both high: mem SHALL win unless last grant was mem, then IF wins (alternation); last-grant register resets to IF.
REQ-005 On grant, address, we, wdata and be SHALL be latched; later input changes are ignored until DONE; IF grants are always reads.
REQ-006 Read: IDLE->RD1->RD2->DONE; RD1/RD2 drive ce_n=0, oe_n=0, we_n=1, be_n=0000, drive=0, addr=latched.
REQ-007 sram_rdata_i SHALL be sampled at end of RD2 into the granted port's rdata register.
REQ-008 Write: IDLE->WR1->WR2->WR3->DONE; WR1-WR3 drive ce_n=0, oe_n=1, drive=1, addr/wdata latched, be_n=~be latched; we_n=0 in WR2 only.
REQ-009 DONE SHALL assert exactly one of if_ack_o/mem_ack_o for one cycle, deassert all SRAM enables (ce_n=oe_n=we_n=1, be_n=1111, drive=0), then go to IDLE.
REQ-010 Latency from grant cycle (IDLE with req) N: read ack at N+3, write ack at N+4; back-to-back requests from either port restart at IDLE, one idle cycle between accesses.
REQ-011 rdata outputs SHALL hold until overwritten by a later read on the same port; writes leave mem_rdata_o unchanged.
REQ-012 Write with mem_be_i=0000 SHALL run the full WR sequence with be_n=1111 and still ack.
REQ-013 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).
REQ-014 In IDLE all SRAM enables SHALL be inactive and drive=0; sram_addr_o and sram_wdata_o hold last values.

Reset
REQ-015 rst high SHALL immediately force state IDLE, ce_n=oe_n=we_n=1, be_n=1111, drive=0, addr=0, wdata=0, both rdata=0, both acks=0, last-grant=IF.
REQ-016 Reset mid-access SHALL abort without ack; requester must re-present after release; first sampling edge after release is IDLE.

Verification
REQ-017 IF read addr 0x00010, SRAM returns 0x8C220004 -> if_ack_o at N+3, if_rdata_o=0x8C220004, we_n high throughout.
REQ-018 mem write addr 0xABCDE, data 0x12345678, be=0011 -> we_n low only in WR2, be_n=1100, drive=1 WR1-WR3, mem_ack_o at N+4.
REQ-019 Both req held continuously from reset -> grants mem, IF, mem, IF; no cycle with both acks high.
REQ-020 rst asserted during WR2 -> we_n=1, drive=0 same cycle, no ack; after release identical request completes normally.
REQ-021 mem write be=0000 -> full write sequence, be_n=1111 all cycles, ack at N+4, mem_rdata_o unchanged.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if -- bundle of every non-clock, non-reset signal of sram_arbiter.
//
// Signals:
//   if_*    instruction-fetch read port (req/addr in, rdata/ack out)
//   mem_*   data port (req/we/addr/wdata/be in, rdata/ack out)
//   stall_o pipeline stall
//   sram_*  asynchronous SRAM pins (addr, wdata, rdata, drive, active-low enables)
//
// Modports:
//   slave   the arbiter itself
//   master  the environment: CPU ports plus the SRAM device
interface sram_arbiter_if;
  logic        if_req_i;
  logic [19:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;

  logic        mem_req_i;
  logic        mem_we_i;
  logic [19:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;

  logic        stall_o;

  logic [19:0] sram_addr_o;
  logic [31:0] sram_wdata_o;
  logic [31:0] sram_rdata_i;
  logic        sram_drive_o;
  logic        sram_ce_n_o;
  logic        sram_oe_n_o;
  logic        sram_we_n_o;
  logic [3:0]  sram_be_n_o;

  modport slave (
    input  if_req_i, if_addr_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
    input  sram_rdata_i,
    output if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_o,
    output sram_addr_o, sram_wdata_o, sram_drive_o,
    output sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
  );

  modport master (
    output if_req_i, if_addr_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_be_i,
    output sram_rdata_i,
    input  if_rdata_o, if_ack_o, mem_rdata_o, mem_ack_o, stall_o,
    input  sram_addr_o, sram_wdata_o, sram_drive_o,
    input  sram_ce_n_o, sram_oe_n_o, sram_we_n_o, sram_be_n_o
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter -- shares one asynchronous 32-bit SRAM between an instruction
// fetch read port and a data read/write port.
//
// Ports:
//   clk50  sole clock, all state on the rising edge
//   rst    asynchronous active-high reset
//   bus    sram_arbiter_if.slave: both CPU ports, stall, and the SRAM pins
//
// A read takes IDLE->RD1->RD2->DONE, a write IDLE->WR1->WR2->WR3->DONE, with
// the write strobe only in WR2 so address and data are stable around it.
// Every SRAM pin comes straight from a flop whose next value is decoded from
// the next state, so pins change exactly on the edge that enters a state.
module sram_arbiter (
  input logic           clk50,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, RD1, RD2, WR1, WR2, WR3, DONE
  } state_e;

  state_e      state_q, state_d;
  logic        last_mem_q, last_mem_d;   // 1 = previous grant went to the data port
  logic        gnt_mem_q, gnt_mem_d;     // 1 = access in flight belongs to the data port
  logic [3:0]  be_q, be_d;
  logic [19:0] sram_addr_q, sram_addr_d;
  logic [31:0] sram_wdata_q, sram_wdata_d;
  logic        sram_ce_n_q, sram_ce_n_d;
  logic        sram_oe_n_q, sram_oe_n_d;
  logic        sram_we_n_q, sram_we_n_d;
  logic [3:0]  sram_be_n_q, sram_be_n_d;
  logic        sram_drive_q, sram_drive_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;

  always_comb begin
    // NOTE: every variable gets a default before the case statement so no path
    // leaves it unassigned; otherwise synthesis would infer a latch.
    state_d      = state_q;
    last_mem_d   = last_mem_q;
    gnt_mem_d    = gnt_mem_q;
    be_d         = be_q;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        // Data port wins a tie unless it also won the previous grant.
        if (bus.mem_req_i && (!bus.if_req_i || !last_mem_q)) begin
          gnt_mem_d   = 1'b1;
          last_mem_d  = 1'b1;
          sram_addr_d = bus.mem_addr_i;
          if (bus.mem_we_i) begin
            sram_wdata_d = bus.mem_wdata_i;
            be_d         = bus.mem_be_i;
            state_d      = WR1;
          end else begin
            state_d = RD1;
          end
        end else if (bus.if_req_i) begin
          gnt_mem_d   = 1'b0;
          last_mem_d  = 1'b0;
          sram_addr_d = bus.if_addr_i;
          state_d     = RD1;
        end
      end
      RD1: state_d = RD2;
      RD2: begin
        // Data has had two full cycles of output enable; capture it now.
        if (gnt_mem_q) mem_rdata_d = bus.sram_rdata_i;
        else           if_rdata_d  = bus.sram_rdata_i;
        state_d = DONE;
      end
      WR1:     state_d = WR2;
      WR2:     state_d = WR3;
      WR3:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin values for the state being entered; IDLE and DONE keep all inactive.
    sram_ce_n_d  = 1'b1;
    sram_oe_n_d  = 1'b1;
    sram_we_n_d  = 1'b1;
    sram_be_n_d  = 4'b1111;
    sram_drive_d = 1'b0;
    unique case (state_d)
      RD1, RD2: begin
        sram_ce_n_d = 1'b0;
        sram_oe_n_d = 1'b0;
        sram_be_n_d = 4'b0000;
      end
      WR1, WR2, WR3: begin
        sram_ce_n_d  = 1'b0;
        sram_we_n_d  = (state_d != WR2);
        sram_be_n_d  = ~be_d;
        sram_drive_d = 1'b1;
      end
      default: ;
    endcase

    if_ack_d  = (state_d == DONE) && !gnt_mem_d;
    mem_ack_d = (state_d == DONE) &&  gnt_mem_d;
  end

  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_mem_q   <= 1'b0;
      gnt_mem_q    <= 1'b0;
      be_q         <= 4'b0000;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      sram_ce_n_q  <= 1'b1;
      sram_oe_n_q  <= 1'b1;
      sram_we_n_q  <= 1'b1;
      sram_be_n_q  <= 4'b1111;
      sram_drive_q <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // values, so the order of these lines does not matter.
      state_q      <= state_d;
      last_mem_q   <= last_mem_d;
      gnt_mem_q    <= gnt_mem_d;
      be_q         <= be_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      sram_ce_n_q  <= sram_ce_n_d;
      sram_oe_n_q  <= sram_oe_n_d;
      sram_we_n_q  <= sram_we_n_d;
      sram_be_n_q  <= sram_be_n_d;
      sram_drive_q <= sram_drive_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
    end
  end

  assign bus.sram_addr_o  = sram_addr_q;
  assign bus.sram_wdata_o = sram_wdata_q;
  assign bus.sram_ce_n_o  = sram_ce_n_q;
  assign bus.sram_oe_n_o  = sram_oe_n_q;
  assign bus.sram_we_n_o  = sram_we_n_q;
  assign bus.sram_be_n_o  = sram_be_n_q;
  assign bus.sram_drive_o = sram_drive_q;
  assign bus.if_rdata_o   = if_rdata_q;
  assign bus.mem_rdata_o  = mem_rdata_q;
  assign bus.if_ack_o     = if_ack_q;
  assign bus.mem_ack_o    = mem_ack_q;

  // A port stalls from the moment it requests until its ack cycle.
  assign bus.stall_o = (bus.if_req_i  && !bus.if_ack_o) ||
                       (bus.mem_req_i && !bus.mem_ack_o);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter -- directed self-checking bench for sram_arbiter.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_sram_arbiter;

  logic clk50;
  logic rst;
  sram_arbiter_if bus ();

  sram_arbiter dut (
    .clk50 (clk50),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk50 = 1'b0;
  always #5 clk50 = ~clk50;

  int n_checks = 0;
  int n_fail   = 0;
  int both_acks = 0;

  // Per-cycle trace of one access; index 1 is the first cycle after the grant.
  // ctl packs {ce_n, oe_n, we_n, drive, be_n[3:0]}.
  logic [7:0]  tr_ctl   [1:8];
  logic [19:0] tr_addr  [1:8];
  logic [31:0] tr_wdata [1:8];

  localparam logic [7:0] CTL_IDLE = 8'b1110_1111;
  localparam logic [7:0] CTL_READ = 8'b0010_0000;

  always @(negedge clk50)
    if (bus.if_ack_o === 1'b1 && bus.mem_ack_o === 1'b1) both_acks++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk50);
    #1;
  endtask

  function automatic logic [7:0] ctl_now();
    return {bus.sram_ce_n_o, bus.sram_oe_n_o, bus.sram_we_n_o,
            bus.sram_drive_o, bus.sram_be_n_o};
  endfunction

  // Presents one request in the current (IDLE) cycle, scrambles the port
  // inputs after the first cycle to prove they were latched, waits up to
  // 8 cycles for the ack, then steps once more into IDLE.
  task automatic access(input bit is_mem, input bit we, input logic [19:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input string tag, output int lat);
    bit got_ack;
    lat = 0;
    if (is_mem) begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wdata;
      bus.mem_be_i    = be;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end
    #1;
    check({tag, "_stall_req"}, 32'(bus.stall_o), 32'd1);
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      tick();
      tr_ctl[i]   = ctl_now();
      tr_addr[i]  = bus.sram_addr_o;
      tr_wdata[i] = bus.sram_wdata_o;
      if (i == 1) begin
        bus.if_addr_i   = ~addr;
        bus.mem_addr_i  = ~addr;
        bus.mem_wdata_i = ~wdata;
        bus.mem_be_i    = ~be;
        bus.mem_we_i    = ~we;
      end
      got_ack = is_mem ? (bus.mem_ack_o === 1'b1) : (bus.if_ack_o === 1'b1);
      if (got_ack) begin
        lat = i;
        check({tag, "_stall_ack"}, 32'(bus.stall_o), 32'd0);
      end
    end
    bus.if_req_i  = 1'b0;
    bus.mem_req_i = 1'b0;
    tick();
    check({tag, "_idle_ctl"},  32'(ctl_now()), 32'(CTL_IDLE));
    check({tag, "_idle_acks"}, 32'({bus.if_ack_o, bus.mem_ack_o}), 32'd0);
    check({tag, "_idle_addr"}, 32'(bus.sram_addr_o), 32'(addr));
  endtask

  task automatic expect_read(input string tag, input logic [19:0] addr, input int lat);
    check({tag, "_lat"}, 32'(lat), 32'd3);
    for (int i = 1; i <= 2; i++) begin
      check($sformatf("%s_ctl%0d", tag, i),  32'(tr_ctl[i]),  32'(CTL_READ));
      check($sformatf("%s_addr%0d", tag, i), 32'(tr_addr[i]), 32'(addr));
    end
    check({tag, "_done_ctl"}, 32'(tr_ctl[3]), 32'(CTL_IDLE));
  endtask

  task automatic expect_write(input string tag, input logic [19:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input int lat);
    logic [7:0] exp_ctl;
    check({tag, "_lat"}, 32'(lat), 32'd4);
    for (int i = 1; i <= 3; i++) begin
      exp_ctl = {1'b0, 1'b1, (i != 2), 1'b1, ~be};
      check($sformatf("%s_ctl%0d", tag, i),   32'(tr_ctl[i]),   32'(exp_ctl));
      check($sformatf("%s_addr%0d", tag, i),  32'(tr_addr[i]),  32'(addr));
      check($sformatf("%s_wdata%0d", tag, i), tr_wdata[i],      wdata);
    end
    check({tag, "_done_ctl"}, 32'(tr_ctl[4]), 32'(CTL_IDLE));
  endtask

  initial begin
    int lat;
    int ack_cyc[$];
    bit ack_mem[$];

    rst              = 1'b1;
    bus.if_req_i     = 1'b0;
    bus.if_addr_i    = '0;
    bus.mem_req_i    = 1'b0;
    bus.mem_we_i     = 1'b0;
    bus.mem_addr_i   = '0;
    bus.mem_wdata_i  = '0;
    bus.mem_be_i     = '0;
    bus.sram_rdata_i = '0;
    tick();
    tick();

    // Reset state.
    check("rst_ctl",       32'(ctl_now()), 32'(CTL_IDLE));
    check("rst_addr",      32'(bus.sram_addr_o), 32'd0);
    check("rst_wdata",     bus.sram_wdata_o, 32'd0);
    check("rst_if_rdata",  bus.if_rdata_o, 32'd0);
    check("rst_mem_rdata", bus.mem_rdata_o, 32'd0);
    check("rst_acks",      32'({bus.if_ack_o, bus.mem_ack_o}), 32'd0);
    check("rst_stall",     32'(bus.stall_o), 32'd0);
    rst = 1'b0;
    tick();

    // IF read: ack at N+3 with the SRAM word.
    bus.sram_rdata_i = 32'h8C22_0004;
    access(1'b0, 1'b0, 20'h00010, 32'h0, 4'h0, "if_rd", lat);
    expect_read("if_rd", 20'h00010, lat);
    check("if_rd_rdata",  bus.if_rdata_o,  32'h8C22_0004);
    check("if_rd_memrd",  bus.mem_rdata_o, 32'd0);

    // Data-port read lands in mem_rdata only.
    bus.sram_rdata_i = 32'hDEAD_BEEF;
    access(1'b1, 1'b0, 20'h00123, 32'h0, 4'h0, "mem_rd", lat);
    expect_read("mem_rd", 20'h00123, lat);
    check("mem_rd_rdata", bus.mem_rdata_o, 32'hDEAD_BEEF);
    check("mem_rd_ifrd",  bus.if_rdata_o,  32'h8C22_0004);

    // Partial-byte write; read data must not change.
    bus.sram_rdata_i = 32'h0BAD_0BAD;
    access(1'b1, 1'b1, 20'hABCDE, 32'h1234_5678, 4'b0011, "wr", lat);
    expect_write("wr", 20'hABCDE, 32'h1234_5678, 4'b0011, lat);
    check("wr_rdata_keep", bus.mem_rdata_o,  32'hDEAD_BEEF);
    check("wr_wdata_hold", bus.sram_wdata_o, 32'h1234_5678);

    // Write with no byte enables still runs the full sequence and acks.
    access(1'b1, 1'b1, 20'h00042, 32'h55AA_55AA, 4'b0000, "wr0", lat);
    expect_write("wr0", 20'h00042, 32'h55AA_55AA, 4'b0000, lat);
    check("wr0_rdata_keep", bus.mem_rdata_o, 32'hDEAD_BEEF);

    // Both ports requesting continuously from reset: mem, IF, mem, IF with
    // one idle cycle between accesses (acks at 3, 7, 11, 15).
    rst              = 1'b1;
    bus.if_req_i     = 1'b1;
    bus.if_addr_i    = 20'h11111;
    bus.mem_req_i    = 1'b1;
    bus.mem_we_i     = 1'b0;
    bus.mem_addr_i   = 20'h22222;
    bus.sram_rdata_i = 32'hA5A5_A5A5;
    tick();
    check("arb_rst_ifrd",  bus.if_rdata_o,  32'd0);
    check("arb_rst_memrd", bus.mem_rdata_o, 32'd0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (bus.mem_ack_o === 1'b1) begin ack_cyc.push_back(i); ack_mem.push_back(1'b1); end
      if (bus.if_ack_o  === 1'b1) begin ack_cyc.push_back(i); ack_mem.push_back(1'b0); end
    end
    bus.if_req_i  = 1'b0;
    bus.mem_req_i = 1'b0;
    tick();
    check("arb_nacks", 32'(ack_cyc.size()), 32'd4);
    for (int k = 0; k < 4 && k < ack_cyc.size(); k++) begin
      check($sformatf("arb_port%0d", k), 32'(ack_mem[k]), 32'((k % 2) == 0));
      check($sformatf("arb_cyc%0d", k),  32'(ack_cyc[k]), 32'(3 + 4 * k));
    end
    check("arb_ifrd",  bus.if_rdata_o,  32'hA5A5_A5A5);
    check("arb_memrd", bus.mem_rdata_o, 32'hA5A5_A5A5);

    // Reset during WR2 aborts at once with no ack.
    bus.mem_req_i   = 1'b1;
    bus.mem_we_i    = 1'b1;
    bus.mem_addr_i  = 20'h0F0F0;
    bus.mem_wdata_i = 32'hCAFE_F00D;
    bus.mem_be_i    = 4'b1111;
    tick();
    tick();
    check("abort_wr2_we", 32'(bus.sram_we_n_o), 32'd0);
    rst = 1'b1;
    #1;
    check("abort_ctl",   32'(ctl_now()), 32'(CTL_IDLE));
    check("abort_addr",  32'(bus.sram_addr_o), 32'd0);
    check("abort_wdata", bus.sram_wdata_o, 32'd0);
    check("abort_ack",   32'(bus.mem_ack_o), 32'd0);
    bus.mem_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("abort_noack%0d", i), 32'({bus.if_ack_o, bus.mem_ack_o}), 32'd0);
    end
    rst = 1'b0;
    access(1'b1, 1'b1, 20'h0F0F0, 32'hCAFE_F00D, 4'b1111, "rewr", lat);
    expect_write("rewr", 20'h0F0F0, 32'hCAFE_F00D, 4'b1111, lat);

    check("both_acks", 32'(both_acks), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
